// File: rtl/lbist_pkg.sv
// lbist_pkg: shared FSM state type, LFSR constants and next-state functions
// for the logic BIST controller.
package lbist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_DONE
    } lbist_state_e;

    // Fibonacci taps at bits 31, 21, 1 and 0
    localparam logic [31:0] LBIST_PRPG_TAPS     = 32'h8020_0003;
    localparam logic [31:0] LBIST_MISR_POLY_DEF = 32'h0040_0007;

    function automatic logic [31:0] prpg_next(input logic [31:0] p);
        return {p[30:0], ^(p & LBIST_PRPG_TAPS)};
    endfunction

    function automatic logic [31:0] misr_next(input logic [31:0] m, input logic [31:0] poly,
                                              input logic [31:0] d);
        return {m[30:0], 1'b0} ^ (m[31] ? poly : 32'h0) ^ d;
    endfunction

endpackage

// File: rtl/lbist_misr.sv
// lbist_misr: 32-bit multiple-input signature register with synchronous
// load (priority) and compaction enable.
module lbist_misr import lbist_pkg::*; #(
    parameter int          NCHAIN = 8,
    parameter logic [31:0] SEED   = 32'h0000_0000,
    parameter logic [31:0] POLY   = LBIST_MISR_POLY_DEF
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic              i_en,
    input  logic [NCHAIN-1:0] i_data,
    output logic [31:0]       o_sig
);

    logic [31:0] r_sig;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n)
            r_sig <= SEED;
        else if (i_load)
            r_sig <= SEED;
        else if (i_en)
            r_sig <= misr_next(r_sig, POLY, 32'(i_data));
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/lbist_ctrl.sv
// lbist_ctrl: logic BIST sequencer - PRPG-driven scan loads, capture strobes
// and MISR compaction of scan-out, with sticky done and live signature.
module lbist_ctrl import lbist_pkg::*; #(
    parameter int          NCHAIN    = 8,
    parameter logic [31:0] PRPG_SEED = 32'hACE1_2468,
    parameter logic [31:0] MISR_SEED = 32'h0000_0000,
    parameter logic [31:0] MISR_POLY = LBIST_MISR_POLY_DEF
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              i_cfg_lbist_rst,
    input  logic              i_cfg_lbist_start,
    input  logic              i_cfg_lbist_rsb,
    input  logic [15:0]       i_cfg_lbist_pat,
    input  logic [15:0]       i_cfg_chain_depth,
    input  logic [NCHAIN-1:0] i_scan_out,
    output logic              o_scan_en,
    output logic [NCHAIN-1:0] o_scan_in,
    output logic              o_scan_capture,
    output logic              o_lbist_busy,
    output logic              o_lbist_done,
    output logic [31:0]       o_lbist_sig
);

    lbist_state_e r_state;
    logic [31:0]  r_prpg;
    logic [15:0]  r_pat, r_depth, r_pat_cnt, r_bit_cnt;
    logic         r_rsb, r_start_q, r_scan_en, r_capture, r_busy, r_done;

    logic w_start_pulse, w_ready, w_last_bit, w_misr_en, w_misr_load;

    assign w_start_pulse = i_cfg_lbist_start & ~r_start_q;
    assign w_ready       = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_last_bit    = r_bit_cnt == r_depth - 16'd1;
    // the first load shifts out the unknown post-reset chain state; rsb masks it
    assign w_misr_en     = (r_state == ST_SHIFT && !(r_rsb && r_pat_cnt == 16'd0)) ||
                           r_state == ST_UNLOAD;
    assign w_misr_load   = i_cfg_lbist_rst || (w_ready && w_start_pulse);

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_q <= 1'b0;
            r_state   <= ST_IDLE;
            r_prpg    <= PRPG_SEED;
            r_pat     <= '0;
            r_depth   <= 16'd1;
            r_rsb     <= 1'b0;
            r_pat_cnt <= '0;
            r_bit_cnt <= '0;
            r_scan_en <= 1'b0;
            r_capture <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // start history keeps tracking through soft reset so a held start cannot retrigger
            r_start_q <= i_cfg_lbist_start;
            if (i_cfg_lbist_rst) begin
                r_state   <= ST_IDLE;
                r_prpg    <= PRPG_SEED;
                r_pat     <= '0;
                r_depth   <= 16'd1;
                r_rsb     <= 1'b0;
                r_pat_cnt <= '0;
                r_bit_cnt <= '0;
                r_scan_en <= 1'b0;
                r_capture <= 1'b0;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: if (w_start_pulse) begin
                        r_prpg    <= PRPG_SEED;
                        r_pat     <= i_cfg_lbist_pat;
                        r_depth   <= (i_cfg_chain_depth == 16'd0) ? 16'd1 : i_cfg_chain_depth;
                        r_rsb     <= i_cfg_lbist_rsb;
                        r_pat_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_done    <= i_cfg_lbist_pat == 16'd0;
                        r_busy    <= i_cfg_lbist_pat != 16'd0;
                        r_scan_en <= i_cfg_lbist_pat != 16'd0;
                        r_state   <= (i_cfg_lbist_pat == 16'd0) ? ST_DONE : ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        r_prpg    <= prpg_next(r_prpg);
                        r_bit_cnt <= w_last_bit ? 16'd0 : r_bit_cnt + 16'd1;
                        r_scan_en <= !w_last_bit;
                        r_capture <= w_last_bit;
                        r_state   <= w_last_bit ? ST_CAPTURE : ST_SHIFT;
                    end
                    ST_CAPTURE: begin
                        r_capture <= 1'b0;
                        r_scan_en <= 1'b1;
                        r_pat_cnt <= r_pat_cnt + 16'd1;
                        r_state   <= (r_pat_cnt + 16'd1 == r_pat) ? ST_UNLOAD : ST_SHIFT;
                    end
                    ST_UNLOAD: begin
                        r_prpg    <= prpg_next(r_prpg);
                        r_bit_cnt <= w_last_bit ? 16'd0 : r_bit_cnt + 16'd1;
                        r_scan_en <= !w_last_bit;
                        r_busy    <= !w_last_bit;
                        r_done    <= w_last_bit;
                        r_state   <= w_last_bit ? ST_DONE : ST_UNLOAD;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    lbist_misr #(
        .NCHAIN (NCHAIN),
        .SEED   (MISR_SEED),
        .POLY   (MISR_POLY)
    ) u_misr (
        .mclk    (mclk),
        .reset_n (reset_n),
        .i_load  (w_misr_load),
        .i_en    (w_misr_en),
        .i_data  (i_scan_out),
        .o_sig   (o_lbist_sig)
    );

    assign o_scan_en      = r_scan_en;
    assign o_scan_in      = r_scan_en ? r_prpg[NCHAIN-1:0] : '0;
    assign o_scan_capture = r_capture;
    assign o_lbist_busy   = r_busy;
    assign o_lbist_done   = r_done;

endmodule
